// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
// Multi-cycle sequencer for RV32M MUL/DIV/DIVU/REM/REMU. It borrows the
// shared 32-bit ALU: shift-add for multiply, restoring compare/subtract
// for divide. The pipeline stalls while busy is high.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     launch request, sampled only in IDLE
//   funct3    000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU (001..011 unsupported)
//   rs1, rs2  operands, captured on the accepting edge
//   alu_out   result from the shared combinational ALU
//   alu_a     ALU operand A (valid while alu_req)
//   alu_b     ALU operand B (valid while alu_req)
//   alu_ctrl  ALU opcode: ADD=0000, SUB=0001, SLTU=1001
//   alu_req   block owns the ALU this cycle
//   busy      operation in flight
//   done      one-cycle pulse, result valid
//   result    result, held until the next accepted start
//   err       unsupported funct3, valid with done
module alu_muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] alu_out,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    output logic        alu_req,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        err
);

    localparam logic [3:0] CTRL_ADD  = 4'b0000;
    localparam logic [3:0] CTRL_SUB  = 4'b0001;
    localparam logic [3:0] CTRL_SLTU = 4'b1001;

    typedef enum logic [2:0] {
        IDLE, NEG_A, NEG_B, MUL_STEP, DIV_CMP, DIV_SUB, FIX_SIGN, FIN
    } state_t;

    state_t      state, state_next;
    logic [31:0] opa;       // multiplicand, or dividend that becomes the quotient Q
    logic [31:0] opb;       // multiplier, or divisor D
    logic [31:0] racc;      // multiply accumulator, or partial remainder R
    logic [5:0]  cnt;
    logic [2:0]  op;
    logic        neg_q;
    logic        neg_r;
    logic        sub_flag;

    // Decode of the incoming request; only meaningful in IDLE.
    logic unsup_in, div0_in, ovf_in, special_in;
    assign unsup_in   = ~funct3[2] & (funct3[1:0] != 2'b00);
    assign div0_in    = funct3[2] & (rs2 == 32'd0);
    assign ovf_in     = funct3[2] & ~funct3[0] & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);
    assign special_in = unsup_in | div0_in | ovf_in;

    // Working values derived from the registered operation.
    logic        op_signed;
    logic        mul_bit;
    logic [31:0] r_shift;
    logic [31:0] fix_x;
    logic        fix_neg;
    assign op_signed = ~op[0];
    assign mul_bit   = opb[cnt[4:0]];
    assign r_shift   = {racc[30:0], opa[31]};
    assign fix_x     = op[1] ? racc : opa;
    assign fix_neg   = op[1] ? neg_r : neg_q;

    assign busy = (state != IDLE);
    assign done = (state == FIN);

    // Next state and ALU drive; ALU ownership depends on state alone.
    always_comb begin
        state_next = state;
        alu_a      = 32'd0;
        alu_b      = 32'd0;
        alu_ctrl   = CTRL_ADD;
        alu_req    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (special_in)
                        state_next = FIN;
                    else if (funct3 == 3'b000)
                        state_next = MUL_STEP;
                    else
                        state_next = NEG_A;
                end
            end
            NEG_A: begin
                alu_req = 1'b1;
                if (op_signed && opa[31]) begin
                    alu_ctrl = CTRL_SUB;
                    alu_b    = opa;
                end else begin
                    alu_a = opa;
                end
                state_next = NEG_B;
            end
            NEG_B: begin
                alu_req = 1'b1;
                if (op_signed && opb[31]) begin
                    alu_ctrl = CTRL_SUB;
                    alu_b    = opb;
                end else begin
                    alu_a = opb;
                end
                state_next = DIV_CMP;
            end
            MUL_STEP: begin
                alu_req = 1'b1;
                alu_a   = racc;
                alu_b   = mul_bit ? (opa << cnt[4:0]) : 32'd0;
                if (cnt == 6'd31)
                    state_next = FIN;
            end
            DIV_CMP: begin
                alu_req    = 1'b1;
                alu_ctrl   = CTRL_SLTU;
                alu_a      = r_shift;
                alu_b      = opb;
                state_next = DIV_SUB;
            end
            DIV_SUB: begin
                alu_req    = 1'b1;
                alu_ctrl   = CTRL_SUB;
                alu_a      = racc;
                alu_b      = opb;
                state_next = (cnt == 6'd31) ? FIX_SIGN : DIV_CMP;
            end
            FIX_SIGN: begin
                alu_req = 1'b1;
                if (fix_neg) begin
                    alu_ctrl = CTRL_SUB;
                    alu_b    = fix_x;
                end else begin
                    alu_a = fix_x;
                end
                state_next = FIN;
            end
            FIN: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and datapath. The ovf bit shifted out of R in DIV_CMP
    // forces a subtract, since R then exceeds any 32-bit divisor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            opa      <= 32'd0;
            opb      <= 32'd0;
            racc     <= 32'd0;
            cnt      <= 6'd0;
            op       <= 3'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            sub_flag <= 1'b0;
            result   <= 32'd0;
            err      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= rs1;
                        opb   <= rs2;
                        racc  <= 32'd0;
                        cnt   <= 6'd0;
                        op    <= funct3;
                        neg_q <= ~funct3[0] & (rs1[31] ^ rs2[31]);
                        neg_r <= ~funct3[0] & rs1[31];
                        if (unsup_in) begin
                            result <= 32'd0;
                            err    <= 1'b1;
                        end else if (div0_in) begin
                            result <= funct3[1] ? rs1 : 32'hFFFF_FFFF;
                            err    <= 1'b0;
                        end else if (ovf_in) begin
                            result <= funct3[1] ? 32'd0 : 32'h8000_0000;
                            err    <= 1'b0;
                        end
                    end
                end
                NEG_A: begin
                    if (op_signed && opa[31])
                        opa <= alu_out;
                end
                NEG_B: begin
                    if (op_signed && opb[31])
                        opb <= alu_out;
                end
                MUL_STEP: begin
                    if (mul_bit)
                        racc <= alu_out;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        result <= mul_bit ? alu_out : racc;
                        err    <= 1'b0;
                    end
                end
                DIV_CMP: begin
                    racc     <= r_shift;
                    opa      <= {opa[30:0], 1'b0};
                    sub_flag <= racc[31] | ~alu_out[0];
                end
                DIV_SUB: begin
                    if (sub_flag) begin
                        racc   <= alu_out;
                        opa[0] <= 1'b1;
                    end
                    cnt <= cnt + 6'd1;
                end
                FIX_SIGN: begin
                    result <= alu_out;
                    err    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
